id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter CNTW, default 16, bubble counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports id_valid input 1, id_pc input XLEN, id_rs1/id_rs2/id_rd input 5 each, id_rs1_data/id_rs2_data/id_imm input XLEN each, id_funct input 4 ({funct7[5],funct3}): decoded ID-stage instruction fields.
REQ-006 SHALL have control inputs from the decode control unit: id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite (input 1 each), id_ALUOp (input 2).
REQ-007 SHALL have port flush  input  1  taken branch resolved in EX; kill the instruction entering EX.
REQ-008 SHALL have port ex_hold  input  1  downstream busy; freeze the EX register.
REQ-009 SHALL have port stall_out  output  1  hold PC and IF/ID register this cycle.
REQ-010 SHALL have registered outputs ex_valid (1), ex_pc, ex_rs1_data, ex_rs2_data, ex_imm (XLEN), ex_rs1, ex_rs2, ex_rd (5), ex_funct (4), ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite (1), ex_ALUOp (2).
REQ-011 SHALL have port bubble_count  output  CNTW  number of load-use bubbles inserted, registered.

Function
REQ-012 load_use SHALL be combinational: id_valid & ex_valid & ex_memRead & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-013 stall_out SHALL equal (ex_hold | load_use) & ~flush, combinational, no registered delay.
REQ-014 Per rising edge, priority SHALL be flush > ex_hold > load_use > normal load.
REQ-015 flush=1: EX register SHALL load a bubble (ex_valid=0, all ex_ control bits 0, data fields 0) regardless of ex_hold or load_use.
REQ-016 ex_hold=1, flush=0: all ex_ outputs SHALL retain their values.
REQ-017 load_use=1, ex_hold=0, flush=0: EX register SHALL load a bubble; ID instruction is re-presented next cycle by upstream hold.
REQ-018 Normal load: every ex_ field SHALL take its id_ counterpart; ex_valid=id_valid; if id_valid=0 all ex_ control bits SHALL be loaded as 0.
REQ-019 Latency ID->EX SHALL be exactly 1 cycle when no stall, hold or flush.
REQ-020 bubble_count SHALL increment by 1 on each edge where REQ-017 applies, saturating at 2^CNTW-1 (no wrap); flush- and hold-cycles SHALL NOT count.
REQ-021 A bubble SHALL never assert ex_regWrite, ex_memWrite, ex_memRead or ex_branch.
REQ-022 Hazard compare SHALL use the EX register contents of the current cycle only; no forwarding decisions are made in this block.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force ex_valid=0, all ex_ control and data outputs to 0 and bubble_count=0.
REQ-024 While rst=1 stall_out SHALL be 0 (ex_valid=0 implies load_use=0) unless ex_hold=1.
REQ-025 Reset asserted mid-stall SHALL discard the stalled instruction state in EX; first edge after release performs a normal load.

Verification
REQ-026 Normal flow: id_valid=1, id_pc=0x10, id_rd=5, id_regWrite=1, id_ALUOp=2'b10 -> next edge ex_pc=0x10, ex_rd=5, ex_regWrite=1, ex_ALUOp=2'b10, stall_out=0.
REQ-027 Load-use: EX holds lw with ex_rd=3, ex_memRead=1; ID presents id_rs2=3 -> stall_out=1 same cycle, next edge ex_valid=0, bubble_count=1; following edge ID instruction enters EX.
REQ-028 x0 exemption: EX lw with ex_rd=0, ID id_rs1=0 -> stall_out=0, no bubble, bubble_count unchanged.
REQ-029 Flush vs hold: flush=1 and ex_hold=1 same cycle with valid EX store -> stall_out=0, next edge ex_valid=0, ex_memWrite=0.
REQ-030 Hold: ex_hold=1 for 3 cycles with ex_pc=0x20 -> ex_pc stays 0x20, stall_out=1 all 3 cycles, bubble_count unchanged.
REQ-031 Saturation/reset: CNTW=2, force 5 load-use bubbles -> bubble_count=3; assert rst between edges -> bubble_count=0 and ex_valid=0 without a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction entering EX, inserts bubbles on load-use
// hazards or flushes, freezes on downstream hold, and counts load-use bubbles.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  // decoded instruction from ID
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_funct,
  // decode control unit outputs
  input  logic            id_branch,
  input  logic            id_memRead,
  input  logic            id_memToReg,
  input  logic            id_memWrite,
  input  logic            id_ALUSrc,
  input  logic            id_regWrite,
  input  logic [1:0]      id_ALUOp,
  // pipeline control
  input  logic            flush,
  input  logic            ex_hold,
  output logic            stall_out,
  // EX register
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_funct,
  output logic            ex_branch,
  output logic            ex_memRead,
  output logic            ex_memToReg,
  output logic            ex_memWrite,
  output logic            ex_ALUSrc,
  output logic            ex_regWrite,
  output logic [1:0]      ex_ALUOp,
  output logic [CNTW-1:0] bubble_count
);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic load_use;
  logic insert_bubble;
  logic count_bubble;
  logic ctl_en;

  // Hazard detection against the instruction currently held in EX; x0 never
  // carries a real dependency.
  always_comb begin
    load_use = id_valid & ex_valid & ex_memRead & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    // flush overrides everything, so a killed instruction never stalls fetch
    stall_out     = (ex_hold | load_use) & ~flush;
    insert_bubble = flush | (~ex_hold & load_use);
    count_bubble  = ~flush & ~ex_hold & load_use;
    // an invalid slot must not carry live control bits
    ctl_en        = id_valid;
  end

  // ---- ID -> EX stage boundary ----
  // EX register: priority flush > hold > load-use bubble > normal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || (!rst && insert_bubble)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_branch   <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_ALUOp    <= '0;
    end else if (!ex_hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
      ex_branch   <= id_branch   & ctl_en;
      ex_memRead  <= id_memRead  & ctl_en;
      ex_memToReg <= id_memToReg & ctl_en;
      ex_memWrite <= id_memWrite & ctl_en;
      ex_ALUSrc   <= id_ALUSrc   & ctl_en;
      ex_regWrite <= id_regWrite & ctl_en;
      ex_ALUOp    <= id_ALUOp & {2{ctl_en}};
    end
  end

  // Count only genuine load-use bubbles; flush and hold cycles are excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (count_bubble) begin
      bubble_count <= sat_inc(bubble_count);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (CNTW=2 to reach counter saturation).
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int CNTW = 2;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic            id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite;
  logic [1:0]      id_ALUOp;
  logic            flush, ex_hold, stall_out;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic            ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [1:0]      ex_ALUOp;
  logic [CNTW-1:0] bubble_count;

  int n_checks = 0;
  int n_fails  = 0;

  id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_funct(id_funct),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc), .id_regWrite(id_regWrite),
    .id_ALUOp(id_ALUOp), .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_branch(ex_branch), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
    .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite),
    .ex_ALUOp(ex_ALUOp), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_funct = '0;
    id_branch = 0; id_memRead = 0; id_memToReg = 0; id_memWrite = 0;
    id_ALUSrc = 0; id_regWrite = 0; id_ALUOp = '0;
  endtask

  // present a load: rd <- mem
  task automatic put_lw(input logic [XLEN-1:0] pc, input logic [4:0] rd);
    clr_id();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = 5'd1;
    id_memRead = 1; id_memToReg = 1; id_regWrite = 1; id_ALUSrc = 1;
  endtask

  // present an ALU op reading rs1/rs2
  task automatic put_alu(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
    clr_id();
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regWrite = 1; id_ALUOp = 2'b10;
  endtask

  initial begin
    rst = 1; flush = 0; ex_hold = 0;
    clr_id();
    #2;
    // reset state
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_bubble_count", bubble_count, 0);
    chk("rst_stall_out", stall_out, 0);
    ex_hold = 1; #1;
    chk("rst_stall_hold", stall_out, 1);
    ex_hold = 0; rst = 0;

    // normal flow
    put_alu(32'h10, 5'd1, 5'd2, 5'd5);
    id_rs1_data = 32'hAAAA_0001; id_imm = 32'h0000_0123; id_funct = 4'b1000;
    #1;
    chk("norm_stall", stall_out, 0);
    step();
    chk("norm_pc", ex_pc, 32'h10);
    chk("norm_rd", ex_rd, 5);
    chk("norm_regWrite", ex_regWrite, 1);
    chk("norm_ALUOp", ex_ALUOp, 2'b10);
    chk("norm_valid", ex_valid, 1);
    chk("norm_rs1_data", ex_rs1_data, 32'hAAAA_0001);
    chk("norm_imm", ex_imm, 32'h123);
    chk("norm_funct", ex_funct, 4'b1000);

    // load-use on rs2
    put_lw(32'h14, 5'd3);
    step();
    chk("lu_ex_memRead", ex_memRead, 1);
    put_alu(32'h18, 5'd7, 5'd3, 5'd9);
    #1;
    chk("lu_stall", stall_out, 1);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_regWrite", ex_regWrite, 0);
    chk("lu_bubble_memRead", ex_memRead, 0);
    chk("lu_count1", bubble_count, 1);
    chk("lu_stall_release", stall_out, 0);
    step();
    chk("lu_reissue_pc", ex_pc, 32'h18);
    chk("lu_reissue_rd", ex_rd, 9);
    chk("lu_reissue_valid", ex_valid, 1);
    chk("lu_count_hold", bubble_count, 1);

    // x0 exemption
    put_lw(32'h1C, 5'd0);
    id_rs1 = 5'd0;
    step();
    put_alu(32'h20, 5'd0, 5'd0, 5'd6);
    #1;
    chk("x0_stall", stall_out, 0);
    step();
    chk("x0_pc", ex_pc, 32'h20);
    chk("x0_valid", ex_valid, 1);
    chk("x0_count", bubble_count, 1);

    // hold for 3 cycles
    ex_hold = 1;
    put_alu(32'h24, 5'd0, 5'd0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", stall_out, 1);
      step();
      chk("hold_pc", ex_pc, 32'h20);
      chk("hold_count", bubble_count, 1);
    end
    ex_hold = 0;

    // flush beats hold, store in EX
    clr_id();
    id_valid = 1; id_pc = 32'h28; id_rs1 = 5'd1; id_rs2 = 5'd4;
    id_memWrite = 1; id_ALUSrc = 1;
    step();
    chk("st_memWrite", ex_memWrite, 1);
    flush = 1; ex_hold = 1;
    #1;
    chk("flush_stall", stall_out, 0);
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_memWrite", ex_memWrite, 0);
    chk("flush_pc", ex_pc, 0);
    flush = 0; ex_hold = 0;

    // invalid ID instruction: control bits cleared, data still loaded
    clr_id();
    id_pc = 32'h30; id_regWrite = 1; id_memWrite = 1; id_branch = 1;
    step();
    chk("inv_valid", ex_valid, 0);
    chk("inv_regWrite", ex_regWrite, 0);
    chk("inv_memWrite", ex_memWrite, 0);
    chk("inv_branch", ex_branch, 0);
    chk("inv_pc", ex_pc, 32'h30);

    // load-use under hold and under flush does not count
    put_lw(32'h34, 5'd3);
    step();
    put_alu(32'h38, 5'd3, 5'd0, 5'd8);
    ex_hold = 1;
    step();
    chk("luhold_count", bubble_count, 1);
    chk("luhold_pc", ex_pc, 32'h34);
    ex_hold = 0; flush = 1;
    #1;
    chk("luflush_stall", stall_out, 0);
    step();
    chk("luflush_count", bubble_count, 1);
    chk("luflush_valid", ex_valid, 0);
    flush = 0;

    // four more bubbles: total five, counter saturates at 3
    for (int k = 1; k <= 4; k++) begin
      put_lw(32'h34, 5'd3);
      step();
      put_alu(32'h38, 5'd3, 5'd0, 5'd8);
      #1;
      chk("sat_stall", stall_out, 1);
      step();
      chk("sat_count", bubble_count, (k + 1 > 3) ? 3 : k + 1);
      chk("sat_bubble_valid", ex_valid, 0);
    end

    // reset in the middle of a stall, between edges
    put_lw(32'h3C, 5'd3);
    step();
    put_alu(32'h40, 5'd0, 5'd3, 5'd10);
    #1;
    chk("mid_stall", stall_out, 1);
    rst = 1;
    #1;
    chk("async_count", bubble_count, 0);
    chk("async_valid", ex_valid, 0);
    chk("async_pc", ex_pc, 0);
    chk("async_memRead", ex_memRead, 0);
    chk("async_stall", stall_out, 0);
    #1;
    rst = 0;
    step();
    chk("post_rst_pc", ex_pc, 32'h40);
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_count", bubble_count, 0);
    chk("post_rst_stall", stall_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
